// File: rtl/mem_pkg.sv
// Shared types for the data memory access unit: access sizes, FSM states,
// latched request layout and the size/offset alignment rule.
package mem_pkg;
  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RD_WAIT,
    RESP,
    ERR
  } state_e;

  typedef struct packed {
    logic        is_write;
    size_e       size;
    logic [1:0]  offset;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic size_aligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~off[0];
      SZ_WORD: return off == 2'b00;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/lane_steer.sv
// Store-side lane steering: per-lane write enables, lane data placement and
// the alignment verdict for one sized access. Lane k is bits 31-8k -: 8.
module lane_steer
  import mem_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  size_e                  size,
  input  logic [1:0]             offset,
  input  logic [WORD_SIZE-1:0]   write_data,
  output logic [LANES-1:0]       we,
  output logic [WORD_SIZE-1:0]   wdata,
  output logic                   align_ok
);
  assign align_ok = size_aligned(size, offset);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign we[k] = (size == SZ_WORD)
                 | ((size == SZ_BYTE) && (offset == 2'(k)))
                 | ((size == SZ_HALF) && (offset[1] == 1'(k / 2)));
  end

  // Replicating the low byte/half puts the right data on whichever lanes are enabled.
  always_comb begin
    wdata = write_data;
    case (size)
      SZ_BYTE: wdata = {LANES{write_data[LANE_W-1:0]}};
      SZ_HALF: wdata = {2{write_data[2*LANE_W-1:0]}};
      default: wdata = write_data;
    endcase
  end
endmodule

// File: rtl/data_mem_access_unit.sv
// Load/store stage driving four byte-lane synchronous RAM banks.
// Define DATA_MEM_BOUNDS_CHECK_EN to reject addresses beyond the bank range.
module data_mem_access_unit
  import mem_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [31:0]          address,
  input  logic                 is_write,
  input  logic [1:0]           access_size,
  input  logic [WORD_SIZE-1:0] write_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [WORD_SIZE-1:0] read_data,
  output logic [ADDR_W-1:0]    bank_addr,
  output logic [LANES-1:0]     bank_we,
  output logic [WORD_SIZE-1:0] bank_wdata,
  input  logic [WORD_SIZE-1:0] bank_rdata
);
  state_e               state, state_nx;
  mem_req_t             req_q;
  logic [ADDR_W-1:0]    waddr_q;
  logic                 err_q;
  logic [WORD_SIZE-1:0] rdata_q;

  size_e                st_size;
  logic [1:0]           st_off;
  logic [WORD_SIZE-1:0] st_wdata;
  logic [LANES-1:0]     steer_we;
  logic [WORD_SIZE-1:0] steer_wdata;
  logic                 align_ok, oob, req_bad;
  logic [WORD_SIZE-1:0] rd_byte_sh, rd_half_sh, rd_lane;

  // In IDLE the steer judges the incoming request; afterwards it drives the latched one.
  always_comb begin
    st_size  = req_q.size;
    st_off   = req_q.offset;
    st_wdata = req_q.wdata;
    if (state == IDLE) begin
      st_size  = size_e'(access_size);
      st_off   = address[1:0];
      st_wdata = write_data;
    end
  end

  lane_steer #(.WORD_SIZE(WORD_SIZE)) u_steer (
    .size       (st_size),
    .offset     (st_off),
    .write_data (st_wdata),
    .we         (steer_we),
    .wdata      (steer_wdata),
    .align_ok   (align_ok)
  );

`ifdef DATA_MEM_BOUNDS_CHECK_EN
  assign oob = |address[31:ADDR_W+2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[31:ADDR_W+2];
  assign oob = 1'b0;
`endif
  assign req_bad = !align_ok || oob;

  // Right-align the addressed lane(s): byte k sits 8*(3-k) above bit 0, half k at 16 or 0.
  assign rd_byte_sh = bank_rdata >> {2'd3 - req_q.offset, 3'b000};
  assign rd_half_sh = bank_rdata >> {~req_q.offset[1], 4'b0000};

  always_comb begin
    rd_lane = bank_rdata;
    case (req_q.size)
      SZ_BYTE: rd_lane = {{(WORD_SIZE-LANE_W){1'b0}}, rd_byte_sh[LANE_W-1:0]};
      SZ_HALF: rd_lane = {{(WORD_SIZE-2*LANE_W){1'b0}}, rd_half_sh[2*LANE_W-1:0]};
      default: rd_lane = bank_rdata;
    endcase
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b1;
    done       = 1'b0;
    bank_we    = '0;
    bank_wdata = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req) state_nx = req_bad ? ERR : ISSUE;
      end
      ISSUE: begin
        bank_we    = req_q.is_write ? steer_we : '0;
        bank_wdata = steer_wdata;
        state_nx   = req_q.is_write ? RESP : RD_WAIT;
      end
      RD_WAIT: state_nx = RESP;
      RESP, ERR: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= '0;
      waddr_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        req_q   <= '{is_write: is_write, size: size_e'(access_size),
                     offset: address[1:0], wdata: write_data};
        waddr_q <= address[ADDR_W+1:2];
        err_q   <= req_bad;
      end
      if (state == RD_WAIT) rdata_q <= rd_lane;
    end
  end

  assign bank_addr = waddr_q;
  assign error     = err_q;
  assign read_data = rdata_q;
endmodule

// File: tb/tb_data_mem_access_unit.sv
// Randomized bench: byte-array memory model plus per-cycle compare of the handshake and bank port.
module tb_data_mem_access_unit;
  localparam int ADDR_W    = 10;
  localparam int WORDS     = 1 << ADDR_W;
  localparam int MEM_BYTES = 4 * WORDS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        is_write = 1'b0;
  logic [31:0] address = '0;
  logic [1:0]  access_size = '0;
  logic [31:0] write_data = '0;
  logic        busy, done, error;
  logic [31:0] read_data, bank_wdata, bank_rdata;
  logic [ADDR_W-1:0] bank_addr;
  logic [3:0]  bank_we;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int                issue_cyc;
    int                done_cyc;
    bit                err;
    bit                is_load;
    logic [31:0]       rd;
    logic [3:0]        we;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] waddr;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mmem [MEM_BYTES];
  logic [31:0] ram  [WORDS];

  data_mem_access_unit #(.WORD_SIZE(32), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req(req), .address(address), .is_write(is_write),
    .access_size(access_size), .write_data(write_data), .busy(busy), .done(done),
    .error(error), .read_data(read_data), .bank_addr(bank_addr), .bank_we(bank_we),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] we);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (we[k]) m[31-8*k -: 8] = 8'hFF;
    return m;
  endfunction

  // Four byte-lane banks with registered read data.
  initial begin
    for (int w = 0; w < WORDS; w++) ram[w] = init_word(w);
    forever begin
      @(posedge clk);
      bank_rdata <= ram[bank_addr];
      for (int k = 0; k < 4; k++)
        if (bank_we[k]) ram[bank_addr][31-8*k -: 8] <= bank_wdata[31-8*k -: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a, input logic [1:0] sz);
    bit b;
    b = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    if (a >= 32'(MEM_BYTES)) b = 1'b1;
`endif
    return b;
  endfunction

  // Byte-addressed model: byte a lives in word a/4, lane a%4; multi-byte values are big-endian.
  task automatic model_push(input logic [31:0] a, input bit wr, input logic [1:0] sz,
                            input logic [31:0] wd, input int n);
    exp_t e;
    int nb, base, lane;
    logic [7:0] b;
    nb   = 1 << sz;
    base = int'(a % 32'(MEM_BYTES));
    e.err = is_bad(a, sz);
    e.is_load = !wr;
    e.issue_cyc = n;
    e.done_cyc = e.err ? n : (wr ? n + 1 : n + 2);
    e.rd = '0; e.we = '0; e.wdata = '0;
    e.waddr = ADDR_W'(base / 4);
    if (!e.err) begin
      for (int i = 0; i < nb; i++) begin
        lane = (base + i) % 4;
        e.we[lane] = 1'b1;
        if (wr) begin
          b = wd[8*(nb-1-i) +: 8];
          mmem[base + i] = b;
          e.wdata[31-8*lane -: 8] = b;
        end else begin
          e.rd = (e.rd << 8) | 32'(mmem[base + i]);
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Per-cycle compare against the head expectation.
  always @(negedge clk) begin
    bit has, edone, ebusy, eissue;
    exp_t h;
    logic [3:0] ewe;
    if (chk_en) begin
      has = exp_q.size() > 0;
      if (has) h = exp_q[0];
      edone  = has && cyc == h.done_cyc;
      ebusy  = has && cyc >= h.issue_cyc && cyc <= h.done_cyc;
      eissue = has && cyc == h.issue_cyc && !h.err;
      ewe    = (eissue && !h.is_load) ? h.we : 4'b0000;
      chk("busy", 32'(busy), 32'(ebusy));
      chk("done", 32'(done), 32'(edone));
      chk("bank_we", 32'(bank_we), 32'(ewe));
      if (eissue) chk("bank_addr", 32'(bank_addr), 32'(h.waddr));
      if (ewe != 4'b0000) chk("bank_wdata", bank_wdata & lane_mask(ewe), h.wdata);
      if (edone) begin
        chk("error", 32'(error), 32'(h.err));
        if (h.is_load && !h.err) chk("read_data", read_data, h.rd);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_access(input logic [31:0] a, input bit wr, input logic [1:0] sz,
                           input logic [31:0] wd, input bit hold, input bit glitch,
                           input bit rst_mid, output logic [31:0] rd, output bit er,
                           output logic [3:0] we_seen, output int lat);
    int n;
    rd = '0; er = 1'b0; we_seen = '0; lat = -1;
    @(posedge clk); #1;
    address = a; is_write = wr; access_size = sz; write_data = wd; req = 1'b1;
    n = cyc + 1;
    model_push(a, wr, sz, wd, n);
    @(posedge clk); #1;
    req = hold;
    if (glitch) begin
      req = 1'b1; is_write = 1'b1; address = $urandom; access_size = 2'b10;
    end
    if (rst_mid) begin
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      return;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cyc == n) we_seen = bank_we;
      if (glitch && cyc == n + 1) req = 1'b0;
      if (done) begin
        lat = cyc - n; rd = read_data; er = error;
        break;
      end
    end
    chk("done_seen", 32'(lat >= 0), 32'd1);
    if (hold) begin @(posedge clk); #1; end
    req = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, t, a;
    bit er, wr, hd, gl;
    logic [3:0] we;
    logic [1:0] sz;
    int lat;

    for (int i = 0; i < MEM_BYTES; i++) begin
      t = init_word(i / 4);
      mmem[i] = t[31-8*(i%4) -: 8];
    end

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_bank_we", 32'(bank_we), 32'd0);
    chk("rst_bank_addr", 32'(bank_addr), 32'd0);
    chk("rst_bank_wdata", bank_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    do_access(32'h10, 1, 2'b10, 32'hDEADBEEF, 0, 0, 0, rd, er, we, lat);
    chk("st_word_we", 32'(we), 32'h0000000F);
    chk("st_word_lat", 32'(lat), 32'd1);
    do_access(32'h10, 0, 2'b10, 32'h0, 0, 0, 0, rd, er, we, lat);
    chk("ld_word_data", rd, 32'hDEADBEEF);
    chk("ld_word_lat", 32'(lat), 32'd2);
    chk("ld_word_err", 32'(er), 32'd0);

    do_access(32'h21, 1, 2'b00, 32'h000055AB, 0, 0, 0, rd, er, we, lat);
    chk("st_byte_we", 32'(we), 32'h00000002);
    do_access(32'h21, 0, 2'b00, 32'h0, 0, 0, 0, rd, er, we, lat);
    chk("ld_byte_data", rd, 32'h000000AB);
    do_access(32'h20, 0, 2'b10, 32'h0, 0, 0, 0, rd, er, we, lat);
    chk("ld_word_lane1", 32'(rd[23:16]), 32'h000000AB);

    do_access(32'h32, 1, 2'b01, 32'h00FF1234, 0, 0, 0, rd, er, we, lat);
    chk("st_half_we", 32'(we), 32'h0000000C);
    do_access(32'h32, 0, 2'b01, 32'h0, 0, 0, 0, rd, er, we, lat);
    chk("ld_half_data", rd, 32'h00001234);

    do_access(32'h13, 0, 2'b10, 32'h0, 0, 0, 0, rd, er, we, lat);
    chk("misalign_word_err", 32'(er), 32'd1);
    chk("misalign_word_lat", 32'(lat), 32'd0);
    do_access(32'h05, 1, 2'b01, 32'hFFFF, 0, 0, 0, rd, er, we, lat);
    chk("misalign_half_err", 32'(er), 32'd1);
    do_access(32'h08, 0, 2'b11, 32'h0, 0, 0, 0, rd, er, we, lat);
    chk("rsvd_err", 32'(er), 32'd1);
    do_access(32'h10, 0, 2'b10, 32'h0, 0, 0, 0, rd, er, we, lat);
    chk("after_err_clean", 32'(er), 32'd0);

    do_access(32'h10, 0, 2'b10, 32'h0, 1, 0, 0, rd, er, we, lat);
    chk("held_req_data", rd, 32'hDEADBEEF);
    repeat (4) @(posedge clk);
    do_access(32'h20, 0, 2'b10, 32'h0, 0, 1, 0, rd, er, we, lat);
    do_access(32'h10, 0, 2'b10, 32'h0, 0, 0, 1, rd, er, we, lat);
    repeat (3) @(posedge clk);

    do_access(32'h1000, 0, 2'b10, 32'h0, 0, 0, 0, rd, er, we, lat);
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    chk("bounds_err", 32'(er), 32'd1);
`else
    chk("alias_data", rd, init_word(0));
`endif

    for (int i = 0; i < 200; i++) begin
      sz = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 127));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFFF000);
      hd = !wr && ($urandom_range(0, 3) == 0);
      gl = !wr && !hd && ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_access(a, wr, sz, $urandom, hd, gl, 0, rd, er, we, lat);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
